// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer: state encoding and
// default parameter values.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam int          TIMEOUT_DEF  = 255;
    localparam logic [31:0] RESET_PC_DEF = 32'h0;

endpackage

// File: rtl/cpu_seq_ctrl_req_timeout.sv
// Wait-cycle counter for an outstanding memory request; flags expiry when the
// current cycle is the TIMEOUT-th without an ack.
module req_timeout
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    input  logic i_ack,
    input  logic i_clear,
    output logic o_expire
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT);
    localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear || (i_active && i_ack)) begin
            r_cnt <= '0;
        end else if (i_active && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // r_cnt counts completed wait cycles, so this cycle is the last one allowed.
    assign o_expire = i_active && !i_ack && (r_cnt >= LIMIT_M1);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle instruction sequencer: owns PC/IR, walks fetch-decode-execute-
// memory-writeback with req/ack memories, halts at last_pc, traps on errors.
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          TIMEOUT  = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] last_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic        dec_is_load,
    input  logic        dec_is_store,
    input  logic        dec_is_branch,
    input  logic        dec_illegal,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halted,
    output logic        error
);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] w_pc_next;
    logic [31:0] w_pc_adv;
    logic        w_retire;
    logic        w_load_instr;
    logic        w_expire;
    logic        w_req_active;
    logic        w_req_ack;
    logic        w_state_change;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_load_instr) begin
                r_instr <= imem_rdata;
            end
        end
    end

    // One counter serves both memories since only one request is ever open.
    assign w_req_active   = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_req_ack      = (r_state == S_FETCH) ? imem_ack :
                            (r_state == S_MEM)   ? dmem_ack : 1'b0;
    assign w_state_change = (w_state_next != r_state);

    req_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .i_active(w_req_active),
        .i_ack   (w_req_ack),
        .i_clear (w_state_change),
        .o_expire(w_expire)
    );

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_pc_adv     = r_pc + 32'd1;
        w_retire     = 1'b0;
        w_load_instr = 1'b0;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        rf_we        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    w_load_instr = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_expire) begin
                    w_state_next = S_ERR;
                end
            end
            S_DECODE: begin
                w_state_next = dec_illegal ? S_ERR : S_EXEC;
            end
            S_EXEC: begin
                if (dec_is_load || dec_is_store) begin
                    w_state_next = S_MEM;
                end else if (dec_is_branch) begin
                    w_retire = 1'b1;
                    if (br_taken) w_pc_adv = br_target;
                end else begin
                    w_state_next = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_is_store;
                if (dmem_ack) begin
                    if (dec_is_load) w_state_next = S_WB;
                    else             w_retire     = 1'b1;
                end else if (w_expire) begin
                    w_state_next = S_ERR;
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                w_retire = 1'b1;
            end
            default: ;
        endcase
        // The final instruction retires without advancing PC.
        if (w_retire) begin
            if (r_pc == last_pc) begin
                w_state_next = S_HALT;
            end else begin
                w_pc_next    = w_pc_adv;
                w_state_next = run ? S_FETCH : S_IDLE;
            end
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign instr     = r_instr;
    assign retire    = w_retire;
    assign halted    = (r_state == S_HALT);
    assign error     = (r_state == S_ERR);

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: per-instruction cycle traces built from the latency
// rules drive the DUT and give the expected outputs for every cycle.
module tb_cpu_seq_ctrl;

    localparam logic [31:0] RST_PC = 32'h8;
    localparam int          TO     = 4;

    logic        clk = 1'b0;
    logic        rst, run, imem_req, imem_ack, dec_is_load, dec_is_store;
    logic        dec_is_branch, dec_illegal, br_taken, dmem_req, dmem_we, dmem_ack;
    logic        rf_we, retire, halted, error;
    logic [31:0] last_pc, imem_addr, imem_rdata, instr, br_target, pc;

    always #5 clk = ~clk;

    cpu_seq_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .run(run), .last_pc(last_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
        .dec_is_branch(dec_is_branch), .dec_illegal(dec_illegal),
        .br_taken(br_taken), .br_target(br_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .pc(pc), .retire(retire), .halted(halted), .error(error)
    );

    typedef struct {
        logic        run, imem_ack, dmem_ack, ld, st, br, ill, taken;
        logic [31:0] rdata, target;
        logic        e_imem_req, e_dmem_req, e_dmem_we, e_rf_we, e_retire, e_halted, e_error;
        logic [31:0] e_pc, e_instr;
    } cyc_t;

    cyc_t        trace[$];
    cyc_t        cur;
    bit          cmp_en = 1'b0;
    int          cyc_idx = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_pc, m_instr, m_last;
    bit          m_halt, m_err;
    int          s_rf, s_ret, s_dreq, s_ireq;
    int          rf_cyc[$];
    logic [31:0] fetch_addr[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc_idx, act, exp);
        end
    endtask

    function automatic logic [31:0] rf_at(input int i);
        return (i < rf_cyc.size()) ? rf_cyc[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] fa_at(input int i);
        return (i < fetch_addr.size()) ? fetch_addr[i] : 32'hDEAD_BEEF;
    endfunction

    // Cycle with random don't-care inputs; expectations default to "nothing happens".
    function automatic cyc_t blank();
        cyc_t r;
        r.run = 1'($urandom); r.imem_ack = 1'($urandom); r.dmem_ack = 1'($urandom);
        r.ld = 1'($urandom); r.st = 1'($urandom); r.br = 1'($urandom);
        r.ill = 1'($urandom); r.taken = 1'($urandom);
        r.rdata = $urandom; r.target = $urandom;
        r.e_imem_req = 0; r.e_dmem_req = 0; r.e_dmem_we = 0; r.e_rf_we = 0; r.e_retire = 0;
        r.e_halted = m_halt; r.e_error = m_err; r.e_pc = m_pc; r.e_instr = m_instr;
        return r;
    endfunction

    task automatic push_idle(input int n, input bit acks);
        cyc_t r;
        for (int i = 0; i < n; i++) begin
            r = blank();
            r.run = (i == n - 1);
            if (acks) begin r.imem_ack = 1'b1; r.dmem_ack = 1'b1; end
            trace.push_back(r);
        end
    endtask

    task automatic gen_tail(input int n);
        for (int i = 0; i < n; i++) trace.push_back(blank());
    endtask

    task automatic set_dec(inout cyc_t r, input int kind, input bit taken, input logic [31:0] tgt);
        r.ld = (kind == 1); r.st = (kind == 2); r.br = (kind == 3); r.ill = (kind == 4);
        r.taken = taken; r.target = tgt;
    endtask

    task automatic retire_rec(inout cyc_t r, input bit is_br, input bit taken,
                              input logic [31:0] tgt, input bit run_after);
        r.e_retire = 1'b1;
        r.run = run_after;
        trace.push_back(r);
        if (m_pc == m_last) m_halt = 1'b1;
        else begin
            m_pc = (is_br && taken) ? tgt : m_pc + 32'd1;
            if (!run_after) push_idle($urandom_range(1, 3), 1'b0);
        end
    endtask

    // kind: 0 ALU, 1 load, 2 store, 3 branch, 4 illegal; fd/md are ack wait cycles.
    task automatic gen_instr(input int kind, input int fd, input int md, input bit taken,
                             input logic [31:0] tgt, input bit run_after);
        cyc_t r;
        logic [31:0] word;
        word = $urandom;
        if (m_halt || m_err) return;
        for (int j = 0; j <= fd; j++) begin
            r = blank(); r.e_imem_req = 1'b1; r.imem_ack = (j == fd); r.rdata = word;
            trace.push_back(r);
            if (j == TO - 1 && j != fd) begin m_err = 1'b1; return; end
        end
        m_instr = word;
        r = blank(); set_dec(r, kind, taken, tgt); trace.push_back(r);
        if (kind == 4) begin m_err = 1'b1; return; end
        r = blank(); set_dec(r, kind, taken, tgt);
        if (kind == 3) begin retire_rec(r, 1'b1, taken, tgt, run_after); return; end
        trace.push_back(r);
        if (kind != 0) begin
            for (int j = 0; j <= md; j++) begin
                r = blank(); set_dec(r, kind, taken, tgt);
                r.e_dmem_req = 1'b1; r.e_dmem_we = (kind == 2); r.dmem_ack = (j == md);
                if (j == md && kind == 2) begin retire_rec(r, 1'b0, 1'b0, 32'd0, run_after); return; end
                trace.push_back(r);
                if (j == TO - 1 && j != md) begin m_err = 1'b1; return; end
            end
        end
        r = blank(); r.e_rf_we = 1'b1;
        retire_rec(r, 1'b0, 1'b0, 32'd0, run_after);
    endtask

    task automatic start_scn(input logic [31:0] last);
        trace.delete(); rf_cyc.delete(); fetch_addr.delete();
        m_pc = RST_PC; m_instr = '0; m_halt = 1'b0; m_err = 1'b0; m_last = last;
        s_rf = 0; s_ret = 0; s_dreq = 0; s_ireq = 0;
    endtask

    task automatic drive(input cyc_t r);
        run = r.run; imem_ack = r.imem_ack; dmem_ack = r.dmem_ack; imem_rdata = r.rdata;
        dec_is_load = r.ld; dec_is_store = r.st; dec_is_branch = r.br; dec_illegal = r.ill;
        br_taken = r.taken; br_target = r.target;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'($urandom); imem_ack = 1'b1; dmem_ack = 1'b1; last_pc = m_last;
        @(negedge clk);
        chk("rst_imem_req", imem_req, 0); chk("rst_dmem_req", dmem_req, 0);
        chk("rst_rf_we", rf_we, 0);       chk("rst_retire", retire, 0);
        chk("rst_halted", halted, 0);     chk("rst_error", error, 0);
        chk("rst_pc", pc, RST_PC);        chk("rst_instr", instr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic play(input int n);
        for (int i = 0; i < n; i++) begin
            drive(trace[i]); cur = trace[i]; cyc_idx = i; cmp_en = 1'b1;
            @(posedge clk); #1;
        end
        cmp_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("imem_req", imem_req, cur.e_imem_req);
            chk("imem_addr", imem_addr, cur.e_pc);
            chk("dmem_req", dmem_req, cur.e_dmem_req);
            if (cur.e_dmem_req) chk("dmem_we", dmem_we, cur.e_dmem_we);
            chk("rf_we", rf_we, cur.e_rf_we);
            chk("retire", retire, cur.e_retire);
            chk("halted", halted, cur.e_halted);
            chk("error", error, cur.e_error);
            chk("pc", pc, cur.e_pc);
            chk("instr", instr, cur.e_instr);
            if (rf_we) begin s_rf++; rf_cyc.push_back(cyc_idx); end
            if (retire) s_ret++;
            if (dmem_req) s_dreq++;
            if (imem_req) s_ireq++;
            if (imem_req && imem_ack) fetch_addr.push_back(imem_addr);
        end
    end

    initial begin
        int n;
        rst = 1'b1; run = 0; last_pc = 0; imem_ack = 0; dmem_ack = 0; imem_rdata = 0;
        dec_is_load = 0; dec_is_store = 0; dec_is_branch = 0; dec_illegal = 0;
        br_taken = 0; br_target = 0;
        @(posedge clk); #1;

        // Three ALU ops, zero-wait memories, halt on the third.
        start_scn(RST_PC + 32'd2); push_idle(1, 1'b0);
        repeat (3) gen_instr(0, 0, 0, 1'b0, 32'd0, 1'b1);
        gen_tail(4); do_reset(); play(trace.size());
        chk("alu_rf_cnt", s_rf, 3);
        chk("alu_rf_cyc0", rf_at(0), 4); chk("alu_rf_cyc1", rf_at(1), 8); chk("alu_rf_cyc2", rf_at(2), 12);
        chk("alu_pc_final", pc, 32'hA); chk("alu_halted", halted, 1);

        // Load with 3-cycle dmem delay, then store.
        start_scn(RST_PC + 32'd1); push_idle(2, 1'b1);
        gen_instr(1, 1, 3, 1'b0, 32'd0, 1'b0);
        gen_instr(2, 0, 2, 1'b0, 32'd0, 1'b1);
        gen_tail(3); do_reset(); play(trace.size());
        chk("ls_dmem_req_cycles", s_dreq, 7); chk("ls_rf_cnt", s_rf, 1);
        chk("ls_retire_cnt", s_ret, 2);      chk("ls_pc_final", pc, 32'h9);

        // Branches: taken to 5, taken to 0x20, not taken to 0x21, ALU halts.
        start_scn(32'h21); push_idle(1, 1'b0);
        gen_instr(3, 0, 0, 1'b1, 32'h5, 1'b1);
        gen_instr(3, 0, 0, 1'b1, 32'h20, 1'b1);
        gen_instr(3, 1, 0, 1'b0, 32'h99, 1'b1);
        gen_instr(0, 0, 0, 1'b0, 32'd0, 1'b1);
        gen_tail(3); do_reset(); play(trace.size());
        chk("br_fetch0", fa_at(0), 32'h8);  chk("br_fetch1", fa_at(1), 32'h5);
        chk("br_fetch2", fa_at(2), 32'h20); chk("br_fetch3", fa_at(3), 32'h21);
        chk("br_rf_cnt", s_rf, 1);          chk("br_pc_final", pc, 32'h21);

        // Fetch timeout, then async reset out of ERR.
        start_scn(RST_PC + 32'd10); push_idle(1, 1'b0);
        gen_instr(0, 9, 0, 1'b0, 32'd0, 1'b1);
        gen_tail(6); do_reset(); play(trace.size());
        chk("to_fetch_cycles", s_ireq, 4); chk("to_error", error, 1);
        chk("to_imem_req", imem_req, 0);   chk("to_retire_cnt", s_ret, 0);
        #3; rst = 1'b1; #1;
        chk("to_rst_error", error, 0); chk("to_rst_pc", pc, RST_PC);
        @(posedge clk); #1;

        // ALU then illegal opcode.
        start_scn(RST_PC + 32'd5); push_idle(1, 1'b0);
        gen_instr(0, 0, 0, 1'b0, 32'd0, 1'b1);
        gen_instr(4, 0, 0, 1'b0, 32'd0, 1'b1);
        gen_tail(4); do_reset(); play(trace.size());
        chk("ill_retire_cnt", s_ret, 1); chk("ill_rf_cnt", s_rf, 1);
        chk("ill_error", error, 1);      chk("ill_pc", pc, 32'h9);

        // PC wrap from FFFFFFFF to 0, halting at last_pc = 0.
        start_scn(32'h0); push_idle(1, 1'b0);
        gen_instr(3, 0, 0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        gen_instr(0, 0, 0, 1'b0, 32'd0, 1'b1);
        gen_instr(0, 0, 0, 1'b0, 32'd0, 1'b1);
        gen_tail(3); do_reset(); play(trace.size());
        chk("wrap_fetch1", fa_at(1), 32'hFFFF_FFFF); chk("wrap_fetch2", fa_at(2), 32'h0);
        chk("wrap_pc_final", pc, 32'h0);            chk("wrap_halted", halted, 1);

        // Async reset in the middle of a data request.
        start_scn(RST_PC + 32'd5); push_idle(1, 1'b0);
        gen_instr(1, 0, 5, 1'b0, 32'd0, 1'b1);
        n = 0;
        while (n < trace.size() && !trace[n].e_dmem_req) n++;
        do_reset(); play(n + 2);
        #3;
        chk("mid_pre_dmem_req", dmem_req, 1);
        rst = 1'b1; #1;
        chk("mid_dmem_req", dmem_req, 0); chk("mid_pc", pc, RST_PC);
        chk("mid_instr", instr, 0);       chk("mid_halted", halted, 0);
        chk("mid_error", error, 0);
        @(posedge clk); #1;
        start_scn(RST_PC + 32'd3); push_idle(3, 1'b1);
        repeat (4) gen_instr($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
                             1'($urandom), RST_PC + $urandom_range(0, 6), 1'($urandom));
        gen_tail(3); do_reset(); play(trace.size());

        // Random programs.
        for (int s = 0; s < 25; s++) begin
            start_scn(RST_PC + $urandom_range(0, 6));
            push_idle($urandom_range(1, 3), 1'($urandom));
            for (int k = 0; k < 12; k++) begin
                int kind, fd, md;
                kind = $urandom_range(0, 3);
                if ($urandom_range(0, 15) == 0) kind = 4;
                fd = ($urandom_range(0, 19) == 0) ? TO + 1 : $urandom_range(0, 2);
                md = ($urandom_range(0, 19) == 0) ? TO + 1 : $urandom_range(0, 3);
                gen_instr(kind, fd, md, 1'($urandom), RST_PC + $urandom_range(0, 6), 1'($urandom));
            end
            gen_tail(3); do_reset(); play(trace.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
Multi-cycle sequencer for the CPU datapath: register file, ALU, control decoder and instruction/data memories.
- Owns the PC and instruction register.
- Steps each instruction through fetch, decode, execute, memory and writeback using req/ack handshakes to the memories.
- Gates register-file writes, halts after the instruction at last_pc retires, and flags memory timeouts and illegal opcodes.

Parameters:
RESET_PC, 32'h0, PC value loaded on reset (word address)
TIMEOUT, 255, max cycles a memory req may wait for ack before ERR (must be >= 1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
run  in  1  start/continue enable
last_pc  in  32  PC of final program instruction
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address (= pc)
imem_ack  in  1  fetch data valid
imem_rdata  in  32  fetched instruction
instr  out  32  instruction register, drives decoder/rf addresses
dec_is_load  in  1  decoded load
dec_is_store  in  1  decoded store
dec_is_branch  in  1  decoded branch/jump
dec_illegal  in  1  decoder rejects instr
br_taken  in  1  branch condition from ALU
br_target  in  32  branch target
dmem_req  out  1  data memory request
dmem_we  out  1  data write (store)
dmem_ack  in  1  data access complete
rf_we  out  1  register file write strobe
pc  out  32  current PC
retire  out  1  one-cycle pulse per completed instruction
halted  out  1  sticky, after last_pc retires
error  out  1  sticky, illegal instr or timeout

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
- Reset (async, any state, mid-handshake included): state=IDLE, pc=RESET_PC, instr=0, timeout counter=0. All strobes/req outputs deassert immediately; halted=0, error=0.
- IDLE: all strobes 0. run=1 -> FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - ack sampled at clk edge while req high; same-cycle ack is legal.
  - On ack: instr<=imem_rdata, counter cleared -> DECODE.
  - Else counter++; counter reaching TIMEOUT without ack -> ERR.
- DECODE: one cycle. dec_illegal=1 -> ERR, else EXEC.
- EXEC: one cycle (ALU settles).
  - load or store -> MEM.
  - branch -> retire.
  - else -> WB.
- MEM: dmem_req=1, dmem_we=dec_is_store; same ack/timeout rules as FETCH.
  - On ack: load -> WB; store -> retire.
- WB: rf_we=1 for exactly one cycle -> retire.
- Retire (on the transition out of EXEC, MEM or WB): retire=1 for one cycle.
  - If pc==last_pc: pc unchanged -> HALT.
  - Else pc <= (dec_is_branch && br_taken) ? br_target : pc+1 (mod 2^32, wraps FFFFFFFF->0).
  - Then run=1 -> FETCH, else IDLE.
- rf_we is never asserted outside WB; stores and branches never write the register file.
- HALT: halted=1, no requests, ignores run; exits only on rst.
- ERR: error=1, no requests, pc/instr frozen for debug; exits only on rst.
- Ack while corresponding req low: ignored.
- Decoder inputs sampled only in DECODE/EXEC/MEM; values at other times are don't-care.
- Latency, zero-wait memory: ALU op 4 cycles (F,D,E,W); load 5; store 4; branch 3.
- Counter width: clog2(TIMEOUT+1), saturating, cleared on every state entry.

Decomposition:
- Shared package cpu_pkg: state encoding localparams (3-bit), TIMEOUT default, PC reset constant.
- One natural sub-module: req_timeout (counter + expire flag, cleared on ack/state change), instantiated once and shared by FETCH and MEM.

Test Plan:
- ALU op, zero-wait memories: RESET_PC=0, run=1, last_pc=2, three ALU instrs -> rf_we pulses at cycles 4,8,12; pc steps 0,1,2; halted=1 after third retire; pc stays 2.
- Load with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, one rf_we pulse, retire once; store -> dmem_we=1, rf_we never asserted.
- Branch at pc=5, br_taken=1, br_target=0x20 -> next imem_addr=0x20, no rf_we. Same with br_taken=0 -> next imem_addr=6.
- TIMEOUT=4, imem_ack held 0 -> ERR entered after 4 FETCH cycles, error=1, imem_req drops; run toggling has no effect until rst.
- dec_illegal=1 in DECODE -> ERR, no rf_we, no retire. pc=FFFFFFFF (last_pc=0) retiring ALU op -> pc wraps to 0.
- rst asserted mid-MEM with dmem_req high -> dmem_req low same cycle (async), pc=RESET_PC, halted/error=0; spurious dmem_ack in IDLE ignored.
